// File: rtl/z16_button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, polarity fix and press/release debounce FSM
// producing a debounced level plus registered press, release and long-press pulses.
module z16_button_debouncer #(
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 200,
    parameter int unsigned CNT_W           = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    localparam logic             REL_VAL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam bit               LONG_EN   = (HOLD_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = LONG_EN ? CNT_W'(HOLD_CYCLES - 1) : CNT_ZERO;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("z16_button_debouncer: DEBOUNCE_CYCLES must be at least 1");
    end
    if (HOLD_CYCLES != 0 && HOLD_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_hold
        $error("z16_button_debouncer: HOLD_CYCLES must be 0 or greater than DEBOUNCE_CYCLES");
    end

    logic             sync1_q, sync2_q;
    logic             s_btn;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             long_done_q, long_done_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             long_hit;

    // s_btn is 1 while the synchronised pin reads "pressed", whatever the board polarity
    assign s_btn    = sync2_q ^ REL_VAL;
    assign long_hit = LONG_EN && (hcnt_q == HOLD_LAST) && !long_done_q;

    // State register: synchroniser, FSM, counters and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q     <= REL_VAL;
            sync2_q     <= REL_VAL;
            state_q     <= ST_IDLE;
            dcnt_q      <= CNT_ZERO;
            hcnt_q      <= CNT_ZERO;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= i_button;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    // Next-state logic and debounce / hold counters
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        case (state_q)
            ST_IDLE: begin
                if (s_btn) begin
                    state_d = ST_PRESS_WAIT;
                    dcnt_d  = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s_btn) begin
                    state_d = ST_IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d     = ST_PRESSED;
                    hcnt_d      = CNT_ZERO;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                // The done flag keeps o_long to one pulse even after hcnt saturates
                if (long_hit) begin
                    long_done_d = 1'b1;
                end else begin
                    long_done_d = long_done_q;
                end
                if (!s_btn) begin
                    state_d = ST_RELEASE_WAIT;
                    dcnt_d  = CNT_ZERO;
                end else if (hcnt_q < HOLD_LAST) begin
                    hcnt_d = hcnt_q + CNT_ONE;
                end else begin
                    hcnt_d = hcnt_q;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s_btn) begin
                    state_d = ST_PRESSED;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dcnt_d  = CNT_ZERO;
            end
        endcase
    end

    // Output logic: next values of the registered level and pulses
    always_comb begin
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                level_d = 1'b0;
            end
            ST_PRESS_WAIT: begin
                if (s_btn && dcnt_q == DEB_LAST) begin
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    level_d = 1'b0;
                end
            end
            ST_PRESSED: begin
                level_d = 1'b1;
                long_d  = long_hit;
            end
            ST_RELEASE_WAIT: begin
                if (!s_btn && dcnt_q == DEB_LAST) begin
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    level_d = 1'b1;
                end
            end
            default: begin
                level_d = 1'b0;
            end
        endcase
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;

endmodule

// File: tb/tb_z16_button_debouncer.sv
// Directed bench for z16_button_debouncer with ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
module tb_z16_button_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic o_level, o_press, o_release, o_long;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    z16_button_debouncer #(
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .CNT_W           (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_button  (btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    task automatic test_reset();
        rst = 1'b1;
        btn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_level, o_press, o_release, o_long} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000", {o_level, o_press, o_release, o_long});
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 6) begin
                n_checks++;
                if (o_press !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_press_early: o_press got %b expected 0 at edge %0d", o_press, i);
                end
            end
            if (i == 7) begin
                n_checks++;
                if ({o_press, o_level} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL held_press: press,level got %b expected 11", {o_press, o_level});
                end
            end
            if (i == 8) begin
                n_checks++;
                if ({o_press, o_level} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL held_press_pulse: press,level got %b expected 01", {o_press, o_level});
                end
            end
        end
        btn = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (o_level !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_level: got %b expected 0", o_level);
        end
    endtask

    task automatic run_bounce(input int low_cycles, input int exp_press);
        int np = 0;
        int nr = 0;
        int lvl_seen = 0;
        btn = 1'b0;
        for (int i = 0; i < low_cycles + 20; i++) begin
            if (i == low_cycles) btn = 1'b1;
            @(negedge clk);
            if (o_press === 1'b1) np++;
            if (o_release === 1'b1) nr++;
            if (o_level === 1'b1) lvl_seen = 1;
        end
        n_checks++;
        if (np != exp_press) begin
            n_fail++;
            $display("FAIL bounce_press_%0d: press count got %0d expected %0d", low_cycles, np, exp_press);
        end
        n_checks++;
        if (nr != exp_press) begin
            n_fail++;
            $display("FAIL bounce_release_%0d: release count got %0d expected %0d", low_cycles, nr, exp_press);
        end
        n_checks++;
        if (lvl_seen != exp_press) begin
            n_fail++;
            $display("FAIL bounce_level_%0d: level seen got %0d expected %0d", low_cycles, lvl_seen, exp_press);
        end
    endtask

    task automatic test_bounce();
        run_bounce(3, 0);
        run_bounce(4, 0);
        run_bounce(5, 1);
    endtask

    task automatic test_glitch();
        int np = 0;
        int nr = 0;
        int lvl_low = 0;
        btn = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 7) begin
                n_checks++;
                if (o_press !== 1'b1) begin
                    n_fail++;
                    $display("FAIL glitch_first_press: got %b expected 1", o_press);
                end
            end
        end
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_press === 1'b1) np++;
            if (o_release === 1'b1) nr++;
            if (o_level !== 1'b1) lvl_low = 1;
        end
        n_checks++;
        if (nr != 0) begin
            n_fail++;
            $display("FAIL glitch_release: release count got %0d expected 0", nr);
        end
        n_checks++;
        if (np != 0) begin
            n_fail++;
            $display("FAIL glitch_repress: press count got %0d expected 0", np);
        end
        n_checks++;
        if (lvl_low != 0) begin
            n_fail++;
            $display("FAIL glitch_level: level dropped got %0d expected 0", lvl_low);
        end
        btn = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_long();
        int nl = 0;
        int idx = -1;
        btn = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 7) begin
                n_checks++;
                if (o_press !== 1'b1) begin
                    n_fail++;
                    $display("FAIL long_press: got %b expected 1", o_press);
                end
            end
            if (o_long === 1'b1) begin
                nl++;
                idx = i;
            end
        end
        n_checks++;
        if (nl != 1) begin
            n_fail++;
            $display("FAIL long_count: got %0d expected 1", nl);
        end
        n_checks++;
        if (idx != 27) begin
            n_fail++;
            $display("FAIL long_timing: pulse at cycle %0d expected 27", idx);
        end
        btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 6) begin
                n_checks++;
                if ({o_release, o_level} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL release_early: release,level got %b expected 01", {o_release, o_level});
                end
            end
            if (i == 7) begin
                n_checks++;
                if ({o_release, o_level} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL release: release,level got %b expected 10", {o_release, o_level});
                end
            end
            if (i == 8) begin
                n_checks++;
                if ({o_release, o_level} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL release_pulse: release,level got %b expected 00", {o_release, o_level});
                end
            end
        end
    endtask

    task automatic test_reset_async();
        int np = 0;
        int nr = 0;
        btn = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_level, o_press, o_release, o_long} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_rst_wait: got %b expected 0000", {o_level, o_press, o_release, o_long});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_press === 1'b1) np++;
        end
        btn = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (o_press === 1'b1) np++;
        end
        n_checks++;
        if (np != 0) begin
            n_fail++;
            $display("FAIL async_rst_no_press: press count got %0d expected 0", np);
        end
        btn = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (o_level !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst_pre_level: got %b expected 1", o_level);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (o_level !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_level: got %b expected 0", o_level);
        end
        @(negedge clk);
        btn = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (o_release === 1'b1) nr++;
        end
        n_checks++;
        if (nr != 0) begin
            n_fail++;
            $display("FAIL async_rst_no_release: release count got %0d expected 0", nr);
        end
    endtask

    task automatic test_toggle();
        int npulse = 0;
        int lvl_hi = 0;
        for (int i = 0; i < 100; i++) begin
            btn = ~btn;
            @(negedge clk);
            if (o_press === 1'b1 || o_release === 1'b1 || o_long === 1'b1) npulse++;
            if (o_level !== 1'b0) lvl_hi++;
        end
        n_checks++;
        if (npulse != 0) begin
            n_fail++;
            $display("FAIL toggle_pulses: got %0d expected 0", npulse);
        end
        n_checks++;
        if (lvl_hi != 0) begin
            n_fail++;
            $display("FAIL toggle_level: level high cycles got %0d expected 0", lvl_hi);
        end
        btn = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        test_reset();
        test_bounce();
        test_glitch();
        test_long();
        test_reset_async();
        test_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
